ram_be_clr: RTL and testbench
=============================

RAM_BE_CLR -- requirements
Module: ram_be_clr

Interface
REQ-001 SHALL have parameter CAddrLen, default 8, address width; depth = 2^CAddrLen words.
REQ-002 SHALL have parameter CDataLen, default 16, data width; a multiple of 8; CByteLen = CDataLen/8.
REQ-003 SHALL have port AClkH, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port AResetN, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port AClkHEn, input, 1, clock enable; when low, all state holds, including the memory array.
REQ-006 SHALL have port AAddr, input, CAddrLen, host word address.
REQ-007 SHALL have port AMosi, input, CDataLen, host write data.
REQ-008 SHALL have port AWrEn, input, CByteLen, per-byte write enable; bit i covers AMosi[8i+7:8i].
REQ-009 SHALL have port ARdEn, input, 1, host read request.
REQ-010 SHALL have port AMiso, output, CDataLen, read data.
REQ-011 SHALL have port AClrReq, input, 1, request to zero the whole array.
REQ-012 SHALL have port ABusy, output, 1, high while clear is in progress.
REQ-013 SHALL have port AClrDone, output, 1, one-cycle pulse when a clear completes.

Function
REQ-014 Memory SHALL be an inferred synchronous array; byte i of the word at AAddr is written when AWrEn[i]=1 on an enabled edge.
REQ-015 Read latency SHALL be 1 enabled cycle; the read enable is registered as FRdEn on each enabled edge.
REQ-016 AMiso SHALL equal array data when FRdEn=1, and all-zero otherwise.
REQ-017 On a read-during-write to the same address, written bytes SHALL return new data and unwritten bytes old data.
REQ-018 FSM SHALL have two states: IDLE and CLEAR; ABusy SHALL be 1 exactly in CLEAR.
REQ-019 IDLE->CLEAR SHALL occur on an enabled edge with AClrReq=1; the clear pointer loads 0.
REQ-020 In CLEAR, each enabled edge SHALL write all-zero to the pointer address (all bytes) and increment the pointer.
REQ-021 After the write to address 2^CAddrLen-1, the FSM SHALL return to IDLE and assert AClrDone for exactly one enabled cycle; a clear takes 2^CAddrLen enabled cycles.
REQ-022 In CLEAR, host writes SHALL be dropped, FRdEn SHALL load 0 (AMiso=0), and AClrReq SHALL be ignored.
REQ-023 AClrReq on the same edge as a host access in IDLE: the host access SHALL complete, then CLEAR is entered.
REQ-024 The pointer SHALL not wrap beyond one sweep; a new AClrReq in IDLE restarts from 0.
REQ-025 AClkHEn low SHALL freeze the pointer, FSM, FRdEn and AClrDone (a pending pulse is stretched until the next enabled edge).

Reset
REQ-026 While AResetN=0 on a clock edge, regardless of AClkHEn: FRdEn=0, pointer=0, AClrDone=0, FSM = reset state (REQ-029/030).
REQ-027 Reset outputs SHALL be: AMiso=0; AClrDone=0; ABusy=0 or 1 as defined in REQ-029/030.
REQ-028 Array contents SHALL NOT be altered by reset; a reset mid-clear aborts the sweep (or restarts it per REQ-029).

Configuration
REQ-029 With RAM_AUTO_CLR_EN defined: FSM reset state SHALL be CLEAR with pointer 0, ABusy=1 during and after reset until the sweep completes, then AClrDone pulses.
REQ-030 Without RAM_AUTO_CLR_EN: FSM reset state SHALL be IDLE, ABusy=0, and a clear starts only via AClrReq.

Verification (CAddrLen=4, CDataLen=16)
REQ-031 Write addr 3 = 16'hA55A, AWrEn=2'b11, then ARdEn at addr 3 -> AMiso=16'hA55A one cycle later; with ARdEn=0 -> AMiso=16'h0000.
REQ-032 Addr 5 holds 16'h1234; write 16'hFFFF with AWrEn=2'b01 while reading addr 5 -> same-cycle read 16'h12FF; next read 16'h12FF.
REQ-033 Fill all 16 words with 16'hBEEF, pulse AClrReq -> ABusy=1 for 16 cycles, AClrDone pulses once, all reads return 16'h0000.
REQ-034 During CLEAR, host write 16'h7777 to addr 15 and ARdEn=1 -> write dropped, AMiso=0; after clear, addr 15 reads 16'h0000.
REQ-035 Drop AClkHEn for 3 cycles mid-clear -> pointer and ABusy hold; total busy = 16 enabled cycles; AClrDone held until next enabled edge.
REQ-036 Assert AResetN=0 at pointer=7 -> with RAM_AUTO_CLR_EN: sweep restarts at 0, ABusy=1 for 16 cycles; without: IDLE, ABusy=0, addresses 7..15 keep old data.

Source files
------------

// File: rtl/ram_be_clr.sv
// Byte-enabled single-port RAM with a registered read and a hardware sweep that zeroes the array.
// Define RAM_AUTO_CLR_EN to make reset enter the clear sweep instead of idling.
module ram_be_clr #(
  parameter int CAddrLen = 8,
  parameter int CDataLen = 16
) (
  input  logic                     AClkH,
  input  logic                     AResetN,
  input  logic                     AClkHEn,
  input  logic [CAddrLen-1:0]      AAddr,
  input  logic [CDataLen-1:0]      AMosi,
  input  logic [(CDataLen/8)-1:0]  AWrEn,
  input  logic                     ARdEn,
  output logic [CDataLen-1:0]      AMiso,
  input  logic                     AClrReq,
  output logic                     ABusy,
  output logic                     AClrDone
);

  localparam int CByteLen = CDataLen / 8;

  typedef enum logic {IDLE, CLEAR} state_t;

`ifdef RAM_AUTO_CLR_EN
  localparam state_t CResetState = CLEAR;
`else
  localparam state_t CResetState = IDLE;
`endif

  state_t               r_state;
  state_t               w_stateNext;
  logic [CAddrLen-1:0]  r_ptr;
  logic                 r_rdEn;
  logic [CDataLen-1:0]  r_rdData;
  logic                 r_clrDone;
  logic [CDataLen-1:0]  r_mem [0:(2**CAddrLen)-1];

  logic                 w_hostOk;
  logic                 w_lastPtr;

  assign w_hostOk  = (r_state == IDLE);
  assign w_lastPtr = &r_ptr;

  always_ff @(posedge AClkH) begin
    if (!AResetN)
      r_state <= CResetState;
    else if (AClkHEn)
      r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (AClrReq)   w_stateNext = CLEAR;
      CLEAR:   if (w_lastPtr) w_stateNext = IDLE;
      default: w_stateNext = CResetState;
    endcase
  end

  always_comb begin
    ABusy    = (r_state == CLEAR);
    AClrDone = r_clrDone;
    AMiso    = r_rdEn ? r_rdData : '0;
  end

  // Pointer sits at 0 in IDLE so every sweep starts from the bottom; it wraps to 0 after the last word.
  always_ff @(posedge AClkH) begin
    if (!AResetN) begin
      r_ptr     <= '0;
      r_rdEn    <= 1'b0;
      r_clrDone <= 1'b0;
    end else if (AClkHEn) begin
      r_rdEn    <= w_hostOk && ARdEn;
      r_clrDone <= (r_state == CLEAR) && w_lastPtr;
      if (r_state == CLEAR)
        r_ptr <= r_ptr + 1'b1;
      else
        r_ptr <= '0;
    end
  end

  // The array is never touched during reset; the sweep owns the write port while clearing.
  always_ff @(posedge AClkH) begin
    if (AResetN && AClkHEn) begin
      if (r_state == CLEAR) begin
        r_mem[r_ptr] <= '0;
      end else begin
        for (int b = 0; b < CByteLen; b++)
          if (AWrEn[b])
            r_mem[AAddr][8*b +: 8] <= AMosi[8*b +: 8];
      end
    end
  end

  // Write-first per byte: bytes written on the same edge are returned instead of the stored ones.
  always_ff @(posedge AClkH) begin
    if (AResetN && AClkHEn && w_hostOk && ARdEn) begin
      for (int b = 0; b < CByteLen; b++)
        r_rdData[8*b +: 8] <= AWrEn[b] ? AMosi[8*b +: 8] : r_mem[AAddr][8*b +: 8];
    end
  end

endmodule

// File: tb/tb_ram_be_clr.sv
// Directed bench for ram_be_clr at 16 words x 16 bits; follows RAM_AUTO_CLR_EN if it is defined.
module tb_ram_be_clr;

  localparam int CAddrLen = 4;
  localparam int CDataLen = 16;

`ifdef RAM_AUTO_CLR_EN
  localparam logic CBusyAtReset = 1'b1;
`else
  localparam logic CBusyAtReset = 1'b0;
`endif

  logic        AClkH = 1'b0;
  logic        AResetN, AClkHEn, ARdEn, AClrReq;
  logic [3:0]  AAddr;
  logic [15:0] AMosi;
  logic [1:0]  AWrEn;
  logic [15:0] AMiso;
  logic        ABusy, AClrDone;

  int total = 0;
  int bad   = 0;

  ram_be_clr #(.CAddrLen(CAddrLen), .CDataLen(CDataLen)) dut (
    .AClkH(AClkH), .AResetN(AResetN), .AClkHEn(AClkHEn), .AAddr(AAddr),
    .AMosi(AMosi), .AWrEn(AWrEn), .ARdEn(ARdEn), .AMiso(AMiso),
    .AClrReq(AClrReq), .ABusy(ABusy), .AClrDone(AClrDone)
  );

  always #5 AClkH = ~AClkH;

  task automatic tick();
    @(posedge AClkH);
    #1;
  endtask

  task automatic hostWrite(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    AAddr = a; AMosi = d; AWrEn = be;
    tick();
    AWrEn = 2'b00;
  endtask

  task automatic readWord(input logic [3:0] a, output logic [15:0] d);
    AAddr = a; ARdEn = 1'b1;
    tick();
    d = AMiso;
    ARdEn = 1'b0;
  endtask

  task automatic test_reset();
    AResetN = 1'b0; AClkHEn = 1'b1; ARdEn = 1'b1; AClrReq = 1'b0;
    AAddr = '0; AMosi = '0; AWrEn = '0;
    tick(); tick();
    total++; if (AMiso !== 16'h0) begin bad++; $display("[TB] FAIL reset_miso got=%h exp=0000", AMiso); end
    total++; if (AClrDone !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", AClrDone); end
    total++; if (ABusy !== CBusyAtReset) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=%b", ABusy, CBusyAtReset); end
    AResetN = 1'b1; ARdEn = 1'b0;
`ifdef RAM_AUTO_CLR_EN
    begin
      int busyCnt = 1;
      int doneCnt = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (ABusy) busyCnt++;
        if (AClrDone) doneCnt++;
      end
      total++; if (busyCnt != 16) begin bad++; $display("[TB] FAIL auto_busy_len got=%0d exp=16", busyCnt); end
      total++; if (doneCnt != 1) begin bad++; $display("[TB] FAIL auto_done_cnt got=%0d exp=1", doneCnt); end
    end
`endif
  endtask

  task automatic test_write_read();
    logic [15:0] d;
    hostWrite(4'd3, 16'hA55A, 2'b11);
    readWord(4'd3, d);
    total++; if (d !== 16'hA55A) begin bad++; $display("[TB] FAIL rd_addr3 got=%h exp=a55a", d); end
    tick();
    total++; if (AMiso !== 16'h0) begin bad++; $display("[TB] FAIL rd_idle_zero got=%h exp=0000", AMiso); end
  endtask

  task automatic test_byte_enable();
    logic [15:0] d;
    hostWrite(4'd5, 16'h1234, 2'b11);
    AAddr = 4'd5; AMosi = 16'hFFFF; AWrEn = 2'b01; ARdEn = 1'b1;
    tick();
    AWrEn = 2'b00; ARdEn = 1'b0;
    total++; if (AMiso !== 16'h12FF) begin bad++; $display("[TB] FAIL rdw_same_cycle got=%h exp=12ff", AMiso); end
    readWord(4'd5, d);
    total++; if (d !== 16'h12FF) begin bad++; $display("[TB] FAIL rdw_after got=%h exp=12ff", d); end
    hostWrite(4'd6, 16'h5566, 2'b11);
    hostWrite(4'd6, 16'h9911, 2'b10);
    readWord(4'd6, d);
    total++; if (d !== 16'h9966) begin bad++; $display("[TB] FAIL hi_byte got=%h exp=9966", d); end
  endtask

  task automatic test_clear();
    logic [15:0] d;
    int busyCnt, doneCnt, nonZero;
    for (int i = 0; i < 16; i++) hostWrite(4'(i), 16'hBEEF, 2'b11);
    AClrReq = 1'b1;
    tick();
    AClrReq = 1'b0;
    busyCnt = ABusy ? 1 : 0;
    doneCnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ABusy) busyCnt++;
      if (AClrDone) doneCnt++;
    end
    total++; if (busyCnt != 16) begin bad++; $display("[TB] FAIL clr_busy_len got=%0d exp=16", busyCnt); end
    total++; if (doneCnt != 1) begin bad++; $display("[TB] FAIL clr_done_cnt got=%0d exp=1", doneCnt); end
    nonZero = 0;
    for (int i = 0; i < 16; i++) begin
      readWord(4'(i), d);
      if (d !== 16'h0) nonZero++;
    end
    total++; if (nonZero != 0) begin bad++; $display("[TB] FAIL clr_contents got=%0d nonzero words exp=0", nonZero); end
  endtask

  task automatic test_clear_blocks_host();
    logic [15:0] d;
    int misoBad;
    hostWrite(4'd15, 16'h1111, 2'b11);
    AClrReq = 1'b1;
    tick();
    misoBad = 0;
    for (int k = 1; k <= 16; k++) begin
      AClrReq = (k < 10);
      ARdEn = 1'b1;
      AWrEn = 2'b00;
      AMosi = 16'h7777;
      if (k == 3) begin AAddr = 4'd15; AWrEn = 2'b11; end
      if (k == 8) begin AAddr = 4'd0;  AWrEn = 2'b11; end
      tick();
      if (AMiso !== 16'h0) misoBad++;
      if (k == 15) begin
        total++; if (ABusy !== 1'b1) begin bad++; $display("[TB] FAIL clr_req_ignored busy got=%b exp=1", ABusy); end
      end
    end
    AClrReq = 1'b0; ARdEn = 1'b0; AWrEn = 2'b00;
    total++; if (misoBad != 0) begin bad++; $display("[TB] FAIL clr_miso got=%0d nonzero exp=0", misoBad); end
    total++; if (ABusy !== 1'b0 || AClrDone !== 1'b1) begin bad++; $display("[TB] FAIL clr_end got busy=%b done=%b exp busy=0 done=1", ABusy, AClrDone); end
    readWord(4'd15, d);
    total++; if (d !== 16'h0) begin bad++; $display("[TB] FAIL clr_drop15 got=%h exp=0000", d); end
    readWord(4'd0, d);
    total++; if (d !== 16'h0) begin bad++; $display("[TB] FAIL clr_drop0 got=%h exp=0000", d); end
  endtask

  task automatic test_back_to_back();
    AAddr = 4'd3; AMosi = 16'h4242; AWrEn = 2'b11; ARdEn = 1'b1; AClrReq = 1'b1;
    tick();
    AWrEn = 2'b00; ARdEn = 1'b0; AClrReq = 1'b0;
    total++; if (AMiso !== 16'h4242 || ABusy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_access got miso=%h busy=%b exp miso=4242 busy=1", AMiso, ABusy); end
    for (int i = 0; i < 17; i++) tick();
    total++; if (ABusy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_end got busy=%b exp=0", ABusy); end
  endtask

  task automatic test_clken();
    logic [15:0] d;
    int busyCnt, stallBad;
    logic seen;
    hostWrite(4'd2, 16'h0102, 2'b11);
    AClkHEn = 1'b0; AAddr = 4'd2; AMosi = 16'hDEAD; AWrEn = 2'b11;
    tick();
    AClkHEn = 1'b1; AWrEn = 2'b00;
    readWord(4'd2, d);
    total++; if (d !== 16'h0102) begin bad++; $display("[TB] FAIL en_write_held got=%h exp=0102", d); end
    AClkHEn = 1'b0;
    tick();
    total++; if (AMiso !== 16'h0102) begin bad++; $display("[TB] FAIL en_rden_held got=%h exp=0102", AMiso); end
    AClkHEn = 1'b1;
    tick();
    total++; if (AMiso !== 16'h0) begin bad++; $display("[TB] FAIL en_rden_release got=%h exp=0000", AMiso); end
    AClrReq = 1'b1;
    tick();
    AClrReq = 1'b0;
    busyCnt = ABusy ? 1 : 0;
    stallBad = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      AClkHEn = !(i >= 4 && i < 7);
      tick();
      if (AClkHEn) begin
        if (ABusy) busyCnt++;
        if (AClrDone) seen = 1'b1;
      end else if (ABusy !== 1'b1) stallBad++;
    end
    AClkHEn = 1'b1;
    total++; if (!seen) begin bad++; $display("[TB] FAIL en_clr_timeout got=no done exp=done"); end
    total++; if (stallBad != 0) begin bad++; $display("[TB] FAIL en_busy_hold got=%0d drops exp=0", stallBad); end
    total++; if (busyCnt != 16) begin bad++; $display("[TB] FAIL en_busy_len got=%0d exp=16", busyCnt); end
    AClkHEn = 1'b0;
    tick(); tick();
    total++; if (AClrDone !== 1'b1) begin bad++; $display("[TB] FAIL en_done_stretch got=%b exp=1", AClrDone); end
    AClkHEn = 1'b1;
    tick();
    total++; if (AClrDone !== 1'b0) begin bad++; $display("[TB] FAIL en_done_release got=%b exp=0", AClrDone); end
  endtask

  task automatic test_reset_mid_clear();
    logic [15:0] d, exp;
    int badWords;
    for (int i = 0; i < 16; i++) hostWrite(4'(i), 16'hC000 + 16'(i), 2'b11);
    AClrReq = 1'b1;
    tick();
    AClrReq = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    AResetN = 1'b0; AClkHEn = 1'b0;
    tick();
    total++; if (ABusy !== CBusyAtReset || AClrDone !== 1'b0 || AMiso !== 16'h0) begin
      bad++; $display("[TB] FAIL midrst_state got busy=%b done=%b miso=%h exp busy=%b done=0 miso=0000", ABusy, AClrDone, AMiso, CBusyAtReset);
    end
    AResetN = 1'b1; AClkHEn = 1'b1;
`ifdef RAM_AUTO_CLR_EN
    begin
      int busyCnt = 1;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (ABusy) busyCnt++;
      end
      total++; if (busyCnt != 16) begin bad++; $display("[TB] FAIL midrst_busy_len got=%0d exp=16", busyCnt); end
    end
`else
    tick();
    total++; if (ABusy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_idle got=%b exp=0", ABusy); end
`endif
    badWords = 0;
    for (int i = 0; i < 16; i++) begin
`ifdef RAM_AUTO_CLR_EN
      exp = 16'h0;
`else
      exp = (i < 7) ? 16'h0 : 16'hC000 + 16'(i);
`endif
      readWord(4'(i), d);
      if (d !== exp) begin
        badWords++;
        $display("[TB] FAIL midrst_addr%0d got=%h exp=%h", i, d, exp);
      end
    end
    total++; if (badWords != 0) bad++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_clear();
    test_clear_blocks_host();
    test_back_to_back();
    test_clken();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
